vball_sprite_dma: RTL and testbench
===================================

Name: vball_sprite_dma

Overview:
- Owns the 256-byte sprite attribute RAM that the sprite renderer reads through its `sma`/`smd` port.
- CPU-side writer with double buffering: the CPU writes a shadow buffer at any time.
- On each vblank rising edge, a DMA engine copies shadow to the display buffer, so the renderer never sees a half-updated sprite list.
- Sits between the main CPU bus decode and the sprite renderer.

Parameters:
- AW, 8, buffer address width (depth 2^AW bytes; 8 gives 256 = 64 sprites x 4 bytes).

Ports:
- clk_sys  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_addr  in  AW  CPU byte address into the shadow buffer.
- cpu_din  in  8  CPU write data.
- cpu_we  in  1  CPU write strobe, one write per cycle high.
- cpu_dout  out  8  registered shadow readback.
- vblank  in  1  vertical blank from the video timing block.
- sma  in  AW  renderer read address.
- smd  out  8  registered display-buffer data.
- dma_busy  out  1  copy in progress.
- frame_done  out  1  one-cycle pulse when a copy completes.

Behaviour:
- Reset values:
  - Outputs `cpu_dout`=0, `smd`=0, `dma_busy`=0, `frame_done`=0.
  - Internal: FSM=IDLE, copy counter=0, vblank delay register `vbl_d`=0.
  - Buffer contents are not cleared by reset (inferred block RAM).
- Shadow buffer, dual-port:
  - Port A (CPU): `cpu_we` writes `shadow[cpu_addr]` <= `cpu_din`; `cpu_dout` <= `shadow[cpu_addr]` every cycle, 1-cycle latency, read-first (a same-cycle write returns the old byte).
  - Port B (DMA read): if a CPU write and a DMA read hit the same address in the same cycle, DMA gets `cpu_din` (forwarded).
- Display buffer, dual-port:
  - Port A (DMA write).
  - Port B (renderer): `smd` <= `display[sma]` every cycle, 1-cycle latency, independent of DMA state. A same-cycle DMA write to `sma` returns the old byte.
- Edge detect: `vbl_d` <= `vblank`; start when `vblank & ~vbl_d` in IDLE. Because `vbl_d` resets to 0, vblank already high at reset release triggers a copy.
- FSM, with edge detected at cycle T:
  - IDLE: on start, go to PRIME with counter=0.
  - PRIME (T+1): issue shadow read of addr 0; counter <= 1; go to COPY.
  - COPY (T+2..T+257): write `display[counter-1]` with the shadow data returned for that address; issue read of addr `counter` while `counter` <= 255. Leave COPY after writing `display[255]` at T+257.
  - DONE (T+258): `frame_done`=1 for this cycle only, then IDLE.
  - `dma_busy`=1 exactly in cycles T+1..T+257; 0 at T+258.
- Counter is AW+1 bits; no wrap of the address counter mid-copy.
- Vblank rising edge while not IDLE: ignored, not queued.
- CPU writes during a copy are never stalled:
  - Write to an already-copied address: reaches shadow only and appears in display next frame.
  - Write to a not-yet-copied address: captured this frame.
- vblank falling mid-copy: copy continues to completion.
- `rst_n` low mid-copy: FSM to IDLE immediately, `dma_busy`/`frame_done` low, display left partially updated (no rollback).

Optional Feature:
- Macro: `SPRITE_DMA_FREEZE_EN`.
- Defined:
  - Adds input port `freeze` (1 bit, after `vblank`).
  - If `freeze`=1 in the start cycle T, no copy occurs: FSM stays IDLE, no `dma_busy`, no `frame_done`, display holds the previous frame (used for pause/debug).
  - `freeze` has no effect on a copy already running.
- Undefined: no `freeze` port; every qualifying vblank edge copies.

Test Plan:
- Reset, then write `shadow[i]`=i^8'h5A for i=0..255 with vblank low; raise vblank at T -> `dma_busy` high T+1..T+257, `frame_done` pulse at T+258. Sweep `sma` 0..255 -> `smd`=i^8'h5A one cycle after each address.
- Before vblank, `display[2]`=8'h11; CPU writes `shadow[2]`=8'h22 at T+10 and `shadow[200]`=8'h33 at T+10 -> after copy, `display[2]`=8'h11 (already copied at T+4) and `display[200]`=8'h33. Next vblank copy -> `display[2]`=8'h22.
- CPU write `shadow[50]`=8'hC3 in the exact cycle DMA reads addr 50 (T+51) -> `display[50]`=8'hC3 after copy. `cpu_dout` for that address in that cycle shows the old byte.
- Toggle vblank low then high at T+100 during a copy -> no second copy; exactly one `frame_done`; `dma_busy` low at T+258.
- Assert `rst_n` low at T+130 -> `dma_busy`=0, `smd`=0 asynchronously. Addresses 0..127 hold new data, 129..255 old; after release with vblank low, no copy starts.
- With `SPRITE_DMA_FREEZE_EN` and `freeze`=1 at the vblank edge -> `dma_busy` stays 0 and display is unchanged. Repeat with `freeze`=0 -> normal 257-cycle copy.

Source files
------------

// File: rtl/vball_sprite_dma.sv
`default_nettype none
// ============================================================================
// Module   : vball_sprite_dma
// Purpose  : Double-buffered sprite attribute RAM. The CPU writes a shadow
//            buffer at any time; on every vblank rising edge a DMA engine
//            copies the whole shadow buffer into the display buffer that the
//            sprite renderer reads, so the renderer never sees a half-updated
//            sprite list.
// Ports    : clk_sys    - system clock, rising edge
//            rst_n      - asynchronous active-low reset
//            cpu_addr   - CPU byte address into the shadow buffer
//            cpu_din    - CPU write data
//            cpu_we     - CPU write strobe (one write per cycle)
//            cpu_dout   - registered shadow readback (read-first)
//            vblank     - vertical blank from the video timing block
//            freeze     - (SPRITE_DMA_FREEZE_EN only) suppress copy start
//            sma        - renderer read address
//            smd        - registered display-buffer data
//            dma_busy   - copy in progress
//            frame_done - one-cycle pulse when a copy completes
// Options  : `define SPRITE_DMA_FREEZE_EN adds the freeze input.
// Revision : 1.0 - initial release
// ============================================================================
module vball_sprite_dma #(
  parameter int AW = 8
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  input  logic          cpu_we,
  output logic [7:0]    cpu_dout,
  input  logic          vblank,
`ifdef SPRITE_DMA_FREEZE_EN
  input  logic          freeze,
`endif
  input  logic [AW-1:0] sma,
  output logic [7:0]    smd,
  output logic          dma_busy,
  output logic          frame_done
);

  localparam int            DEPTH    = 1 << AW;
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_COPY  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [AW:0]   cnt;        // one extra bit so the final address never wraps
  logic          vbl_d;

  logic [7:0]    shadow  [DEPTH];
  logic [7:0]    display [DEPTH];
  logic [7:0]    dma_rdata;

  logic          start;
  logic          rd_en;
  logic          wr_en;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;

`ifdef SPRITE_DMA_FREEZE_EN
  assign start = (state == ST_IDLE) & vblank & ~vbl_d & ~freeze;
`else
  assign start = (state == ST_IDLE) & vblank & ~vbl_d;
`endif

  // PRIME reads address 0 (cnt is 0 there); COPY keeps reading ahead until
  // the counter reaches DEPTH, at which point only the last write remains.
  assign rd_en   = (state == ST_PRIME) | ((state == ST_COPY) & ~cnt[AW]);
  assign rd_addr = cnt[AW-1:0];
  // Write trails the read by one cycle; modular subtraction maps cnt=DEPTH
  // onto the last address.
  assign wr_en   = (state == ST_COPY);
  assign wr_addr = cnt[AW-1:0] - ADDR_ONE;

  // Shadow buffer. DMA port forwards a same-cycle CPU write to the same
  // address so a byte written exactly as it is fetched is captured.
  always_ff @(posedge clk_sys) begin
    if (cpu_we) begin
      shadow[cpu_addr] <= cpu_din;
    end
    if (rd_en) begin
      dma_rdata <= (cpu_we && (cpu_addr == rd_addr)) ? cpu_din : shadow[rd_addr];
    end
  end

  // CPU readback: read-first, so a same-cycle write returns the old byte.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cpu_dout <= 8'h00;
    end else begin
      cpu_dout <= shadow[cpu_addr];
    end
  end

  // Display buffer. The write enable decodes the FSM state, so an
  // asynchronous reset mid-copy blocks any further writes immediately.
  always_ff @(posedge clk_sys) begin
    if (wr_en) begin
      display[wr_addr] <= dma_rdata;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      smd <= 8'h00;
    end else begin
      smd <= display[sma];
    end
  end

  // Copy sequencer with registered status outputs.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      vbl_d      <= 1'b0;
      dma_busy   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      vbl_d      <= vblank;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_PRIME;
            cnt      <= '0;
            dma_busy <= 1'b1;
          end
        end
        ST_PRIME: begin
          cnt   <= CNT_ONE;
          state <= ST_COPY;
        end
        ST_COPY: begin
          if (cnt[AW]) begin
            state      <= ST_DONE;
            dma_busy   <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vball_sprite_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_vball_sprite_dma
// Purpose  : Self-checking bench for vball_sprite_dma. CPU readback vectors
//            come from a table; renderer sweeps use a queue scoreboard fed
//            from a reference model of the shadow and display buffers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vball_sprite_dma;

  logic       clk_sys;
  logic       rst_n;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_din;
  logic       cpu_we;
  logic [7:0] cpu_dout;
  logic       vblank;
`ifdef SPRITE_DMA_FREEZE_EN
  logic       freeze;
`endif
  logic [7:0] sma;
  logic [7:0] smd;
  logic       dma_busy;
  logic       frame_done;

  vball_sprite_dma #(.AW(8)) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .cpu_we     (cpu_we),
    .cpu_dout   (cpu_dout),
    .vblank     (vblank),
`ifdef SPRITE_DMA_FREEZE_EN
    .freeze     (freeze),
`endif
    .sma        (sma),
    .smd        (smd),
    .dma_busy   (dma_busy),
    .frame_done (frame_done)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] din;
    logic [7:0] exp_dout;
  } vec_t;

  typedef struct {
    int         k;
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  vec_t       vecs [8];
  wr_t        wrs [$];
  logic [7:0] sh   [256];
  logic [7:0] disp [256];
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fill(input bit inv);
    for (int i = 0; i < 256; i++) begin
      cpu_we   = 1'b1;
      cpu_addr = 8'(i);
      cpu_din  = inv ? ~8'(i) : (8'(i) ^ 8'h5A);
      sh[i]    = cpu_din;
      tick;
    end
    cpu_we = 1'b0;
    tick;
  endtask

  // Renderer sweep: expected byte queued when the address is driven,
  // popped when smd is due one cycle later.
  task automatic sweep(input int skip);
    logic [7:0] q [$];
    logic [7:0] e;
    for (int i = 0; i < 256; i++) begin
      sma = 8'(i);
      q.push_back(disp[i]);
      tick;
      e = q.pop_front();
      if (i != skip) check($sformatf("smd[%0d]", i), {24'h0, smd}, {24'h0, e});
    end
  endtask

  // One full copy triggered by a vblank rising edge, with CPU writes from
  // wrs injected at cycle T+k. A write at T+k lands in the display this
  // frame only if it is no later than the DMA fetch of that address (T+1+a).
  task automatic do_copy(input int toggle_at);
    logic [7:0] newd [256];
    logic [7:0] exp_old;
    logic [7:0] old_addr;
    bit         pend;
    int         busy_err, done_cnt, done_at;
    busy_err = 0; done_cnt = 0; done_at = -1; pend = 0;
    exp_old = 8'h00; old_addr = 8'h00;
    for (int a = 0; a < 256; a++) newd[a] = sh[a];
    foreach (wrs[j]) if (wrs[j].k <= int'(wrs[j].a) + 1) newd[wrs[j].a] = wrs[j].d;
    vblank = 1'b1;
    for (int k = 1; k <= 262; k++) begin
      tick;
      if (dma_busy !== (k <= 257)) busy_err++;
      if (frame_done === 1'b1) begin done_cnt++; done_at = k; end
      cpu_we = 1'b0;
      if (pend) begin
        check($sformatf("cpu_dout_old[%0d]", old_addr), {24'h0, cpu_dout}, {24'h0, exp_old});
        pend = 0;
      end
      if (k == 5) vblank = 1'b0;
      if (toggle_at > 0 && k == toggle_at) vblank = 1'b1;
      foreach (wrs[j]) begin
        if (wrs[j].k == k) begin
          cpu_we   = 1'b1;
          cpu_addr = wrs[j].a;
          cpu_din  = wrs[j].d;
          exp_old  = sh[wrs[j].a];
          old_addr = wrs[j].a;
          sh[wrs[j].a] = wrs[j].d;
          pend     = 1;
        end
      end
    end
    vblank = 1'b0;
    cpu_we = 1'b0;
    check("busy_window_errors", busy_err, 0);
    check("frame_done_count", done_cnt, 1);
    check("frame_done_cycle", done_at, 258);
    for (int a = 0; a < 256; a++) disp[a] = newd[a];
    wrs.delete();
    tick;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cnt, done_cnt;
    // {we, addr, din, expected cpu_dout next cycle}, after fill with i^5A
    vecs[0] = '{1'b1, 8'd10,  8'hAA, 8'h50};
    vecs[1] = '{1'b0, 8'd10,  8'h00, 8'hAA};
    vecs[2] = '{1'b0, 8'd255, 8'h00, 8'hA5};
    vecs[3] = '{1'b1, 8'd0,   8'h00, 8'h5A};
    vecs[4] = '{1'b0, 8'd0,   8'h00, 8'h00};
    vecs[5] = '{1'b1, 8'd255, 8'hFF, 8'hA5};
    vecs[6] = '{1'b1, 8'd255, 8'h3C, 8'hFF};
    vecs[7] = '{1'b0, 8'd255, 8'h00, 8'h3C};

    rst_n = 1'b0; cpu_addr = 8'h00; cpu_din = 8'h00; cpu_we = 1'b0;
    vblank = 1'b0; sma = 8'h00;
`ifdef SPRITE_DMA_FREEZE_EN
    freeze = 1'b0;
`endif
    tick; tick; tick;
    check("rst_cpu_dout", {24'h0, cpu_dout}, 0);
    check("rst_smd", {24'h0, smd}, 0);
    check("rst_dma_busy", {31'h0, dma_busy}, 0);
    check("rst_frame_done", {31'h0, frame_done}, 0);
    rst_n = 1'b1;
    tick;

    // Basic copy of the i^5A pattern
    fill(0);
    do_copy(0);
    sweep(-1);

    // CPU read-first readback vectors
    for (int i = 0; i < 8; i++) begin
      cpu_we = vecs[i].we; cpu_addr = vecs[i].addr; cpu_din = vecs[i].din;
      tick;
      check($sformatf("cpu_vec%0d", i), {24'h0, cpu_dout}, {24'h0, vecs[i].exp_dout});
      if (vecs[i].we) sh[vecs[i].addr] = vecs[i].din;
    end
    cpu_we = 1'b0;
    tick;

    // Writes during a copy: addr 2 already copied, addr 200 not yet
    cpu_we = 1'b1; cpu_addr = 8'd2; cpu_din = 8'h11; sh[2] = 8'h11;
    tick;
    cpu_we = 1'b0;
    tick;
    do_copy(0);
    wrs.push_back('{10, 8'd2,   8'h22});
    wrs.push_back('{11, 8'd200, 8'h33});
    do_copy(0);
    sweep(-1);
    do_copy(0);
    sweep(-1);

    // Write in the exact cycle the DMA fetches address 50
    wrs.push_back('{51, 8'd50, 8'hC3});
    do_copy(0);
    sweep(-1);

    // Second vblank edge mid-copy is ignored
    do_copy(100);

    // Reset in the middle of a copy
    fill(1);
    vblank = 1'b1;
    for (int k = 1; k <= 130; k++) begin
      tick;
      if (k == 5) vblank = 1'b0;
    end
    check("busy_before_rst", {31'h0, dma_busy}, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", {31'h0, dma_busy}, 0);
    check("async_rst_smd", {24'h0, smd}, 0);
    check("async_rst_done", {31'h0, frame_done}, 0);
    for (int a = 0; a < 128; a++) disp[a] = sh[a];
    tick; tick;
    rst_n = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      tick;
      if (dma_busy !== 1'b0) busy_cnt++;
      if (frame_done !== 1'b0) done_cnt++;
    end
    check("post_rst_busy_cycles", busy_cnt, 0);
    check("post_rst_done_pulses", done_cnt, 0);
    sweep(128);

`ifdef SPRITE_DMA_FREEZE_EN
    // Frozen vblank edge: no copy, display untouched
    freeze = 1'b1; vblank = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    for (int k = 1; k <= 300; k++) begin
      tick;
      if (k == 5) vblank = 1'b0;
      if (dma_busy !== 1'b0) busy_cnt++;
      if (frame_done !== 1'b0) done_cnt++;
    end
    freeze = 1'b0;
    check("freeze_busy_cycles", busy_cnt, 0);
    check("freeze_done_pulses", done_cnt, 0);
    sweep(128);
`endif

    // Normal copy restores a fully consistent display
    do_copy(0);
    sweep(-1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
